// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - shared window geometry, window index type and FSM state encoding
package gauss_pkg;

  // Window edge and element count; the datapath is built for a 5x5 window only.
  localparam int WIN_SZ = 5;
  localparam int WIN_N  = WIN_SZ * WIN_SZ;

  // Index into the row-major window array (0 = oldest row, leftmost column).
  typedef logic [$clog2(WIN_N)-1:0] win_idx_t;

  // Row-major position of window element (r, c).
  function automatic win_idx_t win_idx(input int r, input int c);
    return win_idx_t'(r * WIN_SZ + c);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gauss_line_buf.sv
// rtl/gauss_line_buf.sv - one image line of pixels, registered read, read-before-write
module gauss_line_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DW-1:0]            rdata_o
);

  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic [DW-1:0] rdata_q;

  // Registered read returns the old contents when the same word is written in this cycle.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gauss_window_feeder.sv
// rtl/gauss_window_feeder.sv - raster pixel stream to 5x5 window stream; WIN_STALL_CNT_EN adds stall_cnt
module gauss_window_feeder
  import gauss_pkg::*;
#(
  parameter int COLDepth     = 8,
  parameter int IMG_W        = 32,
  parameter int IMG_H        = 32,
  parameter int Matrix_Scale = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                startW,
  input  logic [COLDepth-1:0] pix_data,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic [COLDepth-1:0] win_data [0:WIN_N-1],
  output logic                win_valid,
  input  logic                win_ready,
  output logic                busy,
  output logic                frame_done
`ifdef WIN_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NLB = WIN_SZ - 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(WIN_SZ - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(WIN_SZ - 1);

  if (Matrix_Scale != WIN_SZ) begin : g_bad_scale
    $error("gauss_window_feeder: only a 5x5 window is implemented");
  end

  state_e                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  last_q, last_d;       // last pixel of the frame already taken
  logic                  win_valid_q, win_valid_d;
  logic [COLDepth-1:0]   win_q [0:WIN_N-1];
  logic [COLDepth-1:0]   lb_rd [0:NLB-1];
  logic                  pix_accept;

  assign pix_ready  = (state_q == ST_RUN) && (!win_valid_q || win_ready) && !last_q;
  assign pix_accept = pix_valid && pix_ready;
  assign win_valid  = win_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign win_data   = win_q;

  // State, raster counters and window handshake register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      last_q      <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      last_q      <= last_d;
      win_valid_q <= win_valid_d;
    end
  end

  // Next-state: frame sequencing, raster position and window-valid tracking.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    last_d      = last_q;
    win_valid_d = win_valid_q;
    case (state_q)
      ST_IDLE: begin
        win_valid_d = 1'b0;
        if (startW) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
          last_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (win_valid_q && win_ready) begin
          win_valid_d = 1'b0;
        end
        if (pix_accept) begin
          win_valid_d = (col_q >= COL_FIRST_WIN) && (row_q >= ROW_FIRST_WIN);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              last_d = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        // Leave once the final window has been handed over.
        if (last_q && (!win_valid_q || win_ready)) begin
          state_d     = ST_DONE;
          win_valid_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        win_valid_d = 1'b0;
      end
      default: begin
        state_d     = ST_IDLE;
        win_valid_d = 1'b0;
      end
    endcase
  end

  // Line buffers are chained: buffer k holds the line k+1 rows above the current one.
  // Reading at col_d keeps each output pointing at the column the next accepted pixel will use.
  for (genvar k = 0; k < NLB; k++) begin : g_lb
    logic [COLDepth-1:0] wdata;
    if (k == 0) begin : g_head
      assign wdata = pix_data;
    end else begin : g_chain
      assign wdata = lb_rd[k-1];
    end
    gauss_line_buf #(
      .DW    (COLDepth),
      .DEPTH (IMG_W)
    ) u_line_buf (
      .clk     (clk),
      .we_i    (pix_accept),
      .waddr_i (col_q),
      .wdata_i (wdata),
      .raddr_i (col_d),
      .rdata_o (lb_rd[k])
    );
  end

  // Window shift: every accepted pixel moves the window one column left and appends a new column.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN_N; i++) begin
        win_q[i] <= '0;
      end
    end else if (pix_accept) begin
      for (int r = 0; r < WIN_SZ; r++) begin
        for (int c = 0; c < WIN_SZ - 1; c++) begin
          win_q[win_idx(r, c)] <= win_q[win_idx(r, c + 1)];
        end
      end
      for (int r = 0; r < NLB; r++) begin
        win_q[win_idx(r, WIN_SZ - 1)] <= lb_rd[NLB-1-r];
      end
      win_q[win_idx(WIN_SZ - 1, WIN_SZ - 1)] <= pix_data;
    end
  end

`ifdef WIN_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count RUN cycles where a window waits on the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if ((state_q == ST_IDLE) && startW) begin
      stall_q <= '0;
    end else if ((state_q == ST_RUN) && win_valid_q && !win_ready) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
